wptr_full_ctrl: RTL

Write-domain pointer and status controller for the asynchronous FIFO. It keeps the binary and Gray write pointers and drives the memory write address and write strobe. It compares its pointer against the read pointer, already synchronised into the write domain by the two-stage synchroniser, to produce full, almost-full, fill level and a sticky overflow flag. Its registered Gray pointer output feeds the synchroniser instance in the read domain.

---
 rtl/fifo_pkg.sv | 39 +++
 rtl/wptr_full_ctrl.sv | 85 ++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared async-FIFO pointer helpers (Gray/binary conversion).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int unsigned MAX_W          = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned PTR_W          = DEF_ADDR_WIDTH + 1;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        logic [MAX_W-1:0] m;
        if (w >= MAX_W) m = '1;
        else            m = (MAX_W'(1) << w) - MAX_W'(1);
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b,
                                                  input int unsigned      w);
        logic [MAX_W-1:0] bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

    // Bits above w are masked to zero, so the full-width prefix XOR is exact.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                  input int unsigned      w);
        logic [MAX_W-1:0] r;
        r = g & width_mask(w);
        for (int i = MAX_W - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ r[i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full_ctrl
// Description : Async FIFO write-domain pointer, full/almost-full/level logic.
// Revision    : 1.0 - initial release
// ============================================================================
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned AFULL_THRESH = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  ovf_clr,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int unsigned           c_PTR_W = ADDR_WIDTH + 1;
    localparam logic [c_PTR_W-1:0]    c_AFULL = c_PTR_W'(AFULL_THRESH);

    logic [c_PTR_W-1:0] r_wbin;
    logic [c_PTR_W-1:0] r_wptr;
    logic               r_wfull;
    logic               r_walmost_full;
    logic [c_PTR_W-1:0] r_wlevel;
    logic               r_woverflow;

    logic               w_wr_accept;
    logic [c_PTR_W-1:0] w_wbin_next;
    logic [c_PTR_W-1:0] w_wgray_next;
    logic [c_PTR_W-1:0] w_rbin_s;
    logic [c_PTR_W-1:0] w_level_next;
    logic [c_PTR_W-1:0] w_full_cmp;
    logic               w_full_next;

    assign w_wr_accept  = wr_en & ~r_wfull;
    assign w_wbin_next  = r_wbin + c_PTR_W'(w_wr_accept);
    assign w_wgray_next = c_PTR_W'(bin2gray(MAX_W'(w_wbin_next), c_PTR_W));
    assign w_rbin_s     = c_PTR_W'(gray2bin(MAX_W'(wq2_rptr), c_PTR_W));
    assign w_level_next = w_wbin_next - w_rbin_s;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign w_full_cmp  = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
    assign w_full_next = (w_wgray_next == w_full_cmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wfull        <= w_full_next;
            r_walmost_full <= (w_level_next >= c_AFULL);
            r_wlevel       <= w_level_next;
            if (wr_en && r_wfull)
                r_woverflow <= 1'b1;
            else if (ovf_clr)
                r_woverflow <= 1'b0;
        end
    end

    assign wr_accept    = w_wr_accept;
    assign waddr        = r_wbin[ADDR_WIDTH-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign woverflow    = r_woverflow;

endmodule
`default_nettype wire
